// File: rtl/dmem_io_bridge_pkg.sv
// rtl/dmem_io_bridge_pkg.sv - shared constants and types for the data-memory / MMIO bridge
// Contents: MMIO register addresses, STATUS bit positions, serial TX FSM state type.
// Config macro TX_PARITY_EN adds the PARITY state to tx_state_t.
package dmem_io_pkg;

   localparam logic [31:0] ADR_TXDATA = 32'h8000_0000;
   localparam logic [31:0] ADR_STATUS = 32'h8000_0004;
   localparam logic [31:0] ADR_CYCLES = 32'h8000_0008;

   localparam int unsigned ST_EMPTY    = 0;
   localparam int unsigned ST_FULL     = 1;
   localparam int unsigned ST_BUSY     = 2;
   localparam int unsigned ST_OVERFLOW = 3;
   localparam int unsigned ST_PARITY   = 4;

`ifdef TX_PARITY_EN
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

endpackage

// File: rtl/dmem_io_bridge_if.sv
// rtl/dmem_io_bridge_if.sv - core-to-data-memory bus
// Signals: MemWrite (store strobe), Adr (byte address), WriteData (store data),
//          ReadData (combinational load data).
// Modports: master = core side, slave = bridge side.
interface dmem_io_bridge_if;
   logic        MemWrite;
   logic [31:0] Adr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   modport master (output MemWrite, output Adr, output WriteData, input ReadData);
   modport slave  (input MemWrite, input Adr, input WriteData, output ReadData);
endinterface

// File: rtl/dmem_io_bridge_sync_fifo.sv
// rtl/dmem_io_bridge_sync_fifo.sv - single-clock FIFO with show-ahead read data
// Ports: clk, reset (sync, active-high), push/wdata, pop/rdata (head, combinational),
//        full, empty, count (entries held).
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CW'(DEPTH));
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end
endmodule

// File: rtl/dmem_io_bridge.sv
// rtl/dmem_io_bridge.sv - data memory plus MMIO page (buffered serial TX, cycle counter)
// Ports: clk, reset (sync, active-high), bus (dmem_io_bridge_if.slave: MemWrite, Adr,
//        WriteData, ReadData), tx (serial line, idle high), tx_irq (FIFO empty and TX idle).
// Config macro TX_PARITY_EN: even parity bit between data and stop, STATUS bit4 reads 1.
module dmem_io_bridge
   import dmem_io_pkg::*;
#(
   parameter int RAM_WORDS    = 64,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   dmem_io_bridge_if.slave   bus,
   output logic              tx,
   output logic              tx_irq
);
   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]       ram_q [RAM_WORDS];
   logic [RAM_AW-1:0] ram_idx;
   logic              is_ram, sel_txdata, sel_status, sel_cycles;
   logic [31:0]       status;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]        fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;

   logic              overflow_q, overflow_d;
   logic [31:0]       cycles_q, cycles_d;
   logic              tx_irq_q, tx_irq_d;

   tx_state_t         state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              tx_q;
   logic              baud_last;
`ifdef TX_PARITY_EN
   logic              parity_q;
`endif

   always_comb begin
      ram_idx    = bus.Adr[RAM_AW+1:2];
      is_ram     = !bus.Adr[31];
      sel_txdata = (bus.Adr == ADR_TXDATA);
      sel_status = (bus.Adr == ADR_STATUS);
      sel_cycles = (bus.Adr == ADR_CYCLES);

      status              = 32'b0;
      status[ST_EMPTY]    = fifo_empty;
      status[ST_FULL]     = fifo_full;
      status[ST_BUSY]     = (state_q != TX_IDLE);
      status[ST_OVERFLOW] = overflow_q;
`ifdef TX_PARITY_EN
      status[ST_PARITY]   = 1'b1;
`endif

      if (is_ram)          bus.ReadData = ram_q[ram_idx];
      else if (sel_status) bus.ReadData = status;
      else if (sel_cycles) bus.ReadData = cycles_q;
      else                 bus.ReadData = 32'b0;
   end

   // The FSM pops in every IDLE cycle that finds data, which is also what lets a
   // push into a full FIFO through in that same cycle.
   always_comb begin
      fifo_push = bus.MemWrite && sel_txdata;
      fifo_pop  = (state_q == TX_IDLE) && !fifo_empty;
      baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

      overflow_d = overflow_q;
      if (bus.MemWrite && sel_status)                overflow_d = 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)  overflow_d = 1'b1;

      cycles_d = (bus.MemWrite && sel_cycles) ? 32'b0 : cycles_q + 32'd1;
      tx_irq_d = (fifo_count == '0) && (state_q == TX_IDLE);
   end

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (bus.WriteData[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (bus.MemWrite && is_ram) ram_q[ram_idx] <= bus.WriteData;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
         cycles_q   <= 32'b0;
         tx_irq_q   <= 1'b1;
      end else begin
         overflow_q <= overflow_d;
         cycles_q   <= cycles_d;
         tx_irq_q   <= tx_irq_d;
      end
   end

   // tx_q is loaded with the level of the bit being entered, so the line is
   // registered and changes exactly on bit boundaries.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            TX_IDLE: begin
               baud_q <= '0;
               bit_q  <= '0;
               tx_q   <= 1'b1;
               if (!fifo_empty) begin
                  shift_q <= fifo_rdata;
                  state_q <= TX_START;
                  tx_q    <= 1'b0;
`ifdef TX_PARITY_EN
                  parity_q <= ^fifo_rdata;
`endif
               end
            end
            TX_START: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= TX_DATA;
                  tx_q    <= shift_q[0];
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            TX_DATA: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
                     state_q <= TX_PARITY;
                     tx_q    <= parity_q;
`else
                     state_q <= TX_STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
`ifdef TX_PARITY_EN
            TX_PARITY: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= TX_STOP;
                  tx_q    <= 1'b1;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
`endif
            TX_STOP: begin
               tx_q <= 1'b1;
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= TX_IDLE;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               state_q <= TX_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx     = tx_q;
   assign tx_irq = tx_irq_q;
endmodule

// File: tb/tb_dmem_io_bridge.sv
// tb/tb_dmem_io_bridge.sv - self-checking bench for dmem_io_bridge
module tb_dmem_io_bridge;
   import dmem_io_pkg::*;

`ifdef TX_PARITY_EN
   localparam int          FB       = 11;
   localparam logic [31:0] PAR_FLAG = 32'h10;
`else
   localparam int          FB       = 10;
   localparam logic [31:0] PAR_FLAG = 32'h0;
`endif
   localparam logic [31:0] ST_IDLE_VAL = 32'h1 | PAR_FLAG;

   logic clk = 1'b0;
   logic reset;
   logic tx, tx_irq;
   int   total = 0;
   int   bad = 0;
   int   frames = 0;
   int   rst_epoch = 0;
   logic [7:0] sb_q[$];

   dmem_io_bridge_if bus();

   dmem_io_bridge #(.RAM_WORDS(64), .FIFO_DEPTH(8), .CLKS_PER_BIT(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .tx     (tx),
      .tx_irq (tx_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.MemWrite = 1'b0;
      bus.Adr      = a;
      #1;
      d = bus.ReadData;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.MemWrite  = 1'b1;
      bus.Adr       = a;
      bus.WriteData = d;
      @(negedge clk);
      bus.MemWrite  = 1'b0;
   endtask

   // Expected tx level in cycle c, where c=1 is the cycle after the TXDATA store.
   function automatic logic exp_tx(input int c, input logic [7:0] b);
      int k;
      if (c < 2) return 1'b1;
      k = (c - 2) / 16;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (FB == 11 && k == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic send_and_check(input logic [7:0] b);
      logic [31:0] r;
      sb_q.push_back(b);
      wr(ADR_TXDATA, {24'h0, b});
      for (int c = 1; c <= FB*16 + 2; c++) begin
         chk($sformatf("frame_%h_tx_c%0d", b, c), {31'b0, tx}, {31'b0, exp_tx(c, b)});
         if (c == 40) begin
            rd(ADR_STATUS, r);
            chk("frame_status_busy", r, 32'h5 | PAR_FLAG);
            chk("frame_irq_low", {31'b0, tx_irq}, 32'h0);
         end
         @(negedge clk);
      end
      chk("frame_irq_high", {31'b0, tx_irq}, 32'h1);
      rd(ADR_STATUS, r);
      chk("frame_status_after", r, ST_IDLE_VAL);
   endtask

   // Frame decoder: samples mid-bit, compares against the scoreboard queue.
   initial begin : monitor
      logic [7:0] b;
      logic [7:0] expb;
      int         ep;
      logic       ok;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         ep = rst_epoch;
         ok = 1'b1;
         repeat (7) @(negedge clk);
         if (rst_epoch != ep) ok = 1'b0;
         else chk("mon_start", {31'b0, tx}, 32'h0);
         for (int i = 0; i < 8; i++) begin
            if (ok) begin
               repeat (16) @(negedge clk);
               if (rst_epoch != ep) ok = 1'b0;
               else b[i] = tx;
            end
         end
`ifdef TX_PARITY_EN
         if (ok) begin
            repeat (16) @(negedge clk);
            if (rst_epoch != ep) ok = 1'b0;
            else chk("mon_parity", {31'b0, tx}, {31'b0, ^b});
         end
`endif
         if (ok) begin
            repeat (16) @(negedge clk);
            if (rst_epoch != ep) ok = 1'b0;
            else chk("mon_stop", {31'b0, tx}, 32'h1);
         end
         if (ok) begin
            frames++;
            chk("mon_sb_nonempty", {31'b0, sb_q.size() != 0}, 32'h1);
            if (sb_q.size() != 0) begin
               expb = sb_q.pop_front();
               chk("mon_byte", {24'h0, b}, {24'h0, expb});
            end
         end else begin
            for (int k = 0; k < 1000 && tx !== 1'b1; k++) @(negedge clk);
         end
      end
   end

   initial begin : stim
      logic [31:0] r;
      int          n;
      int          fb;
      logic        found;
      logic [7:0]  b;

      bus.MemWrite  = 1'b0;
      bus.Adr       = 32'h0;
      bus.WriteData = 32'h0;
      reset         = 1'b1;
      rst_epoch     = 1;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_tx", {31'b0, tx}, 32'h1);
      chk("rst_irq", {31'b0, tx_irq}, 32'h1);
      rd(ADR_STATUS, r); chk("rst_status", r, ST_IDLE_VAL);
      rd(ADR_CYCLES, r); chk("rst_cycles", r, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // RAM, aliasing, unmapped MMIO
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      rd(32'h0000_0010, r); chk("ram_rd", r, 32'hDEAD_BEEF);
      rd(32'h0000_0110, r); chk("ram_alias", r, 32'hDEAD_BEEF);
      rd(32'h0000_0013, r); chk("ram_byte_ofs", r, 32'hDEAD_BEEF);
      wr(32'h0000_1014, 32'h1234_5678);
      rd(32'h0000_0014, r); chk("ram_alias_wr", r, 32'h1234_5678);
      rd(32'h0000_0010, r); chk("ram_neighbour", r, 32'hDEAD_BEEF);
      wr(32'h8000_0010, 32'hFFFF_FFFF);
      rd(32'h8000_0010, r); chk("mmio_unmapped", r, 32'h0);
      rd(32'h0000_0010, r); chk("mmio_no_ram_wr", r, 32'hDEAD_BEEF);
      rd(ADR_TXDATA, r);    chk("txdata_rd0", r, 32'h0);

      // cycle counter: load 0, then count; wrap
      wr(ADR_CYCLES, 32'h1234);
      rd(ADR_CYCLES, r); chk("cycles_load0", r, 32'h0);
      repeat (5) @(negedge clk);
      rd(ADR_CYCLES, r); chk("cycles_5", r, 32'd5);
      @(negedge clk);
      force dut.cycles_q = 32'hFFFF_FFFF;
      #1;
      release dut.cycles_q;
      rd(ADR_CYCLES, r); chk("cycles_max", r, 32'hFFFF_FFFF);
      @(negedge clk);
      rd(ADR_CYCLES, r); chk("cycles_wrap", r, 32'h0);

      // single frame, exact waveform
      send_and_check(8'h55);
`ifdef TX_PARITY_EN
      send_and_check(8'h07);
`endif

      // 10 back-to-back pushes: 9 accepted, 10th dropped
      fb = frames;
      for (int i = 0; i < 10; i++) begin
         b = 8'hA0 + 8'(i);
         if (i < 9) sb_q.push_back(b);
         bus.MemWrite  = 1'b1;
         bus.Adr       = ADR_TXDATA;
         bus.WriteData = {24'h0, b};
         @(negedge clk);
      end
      bus.MemWrite = 1'b0;
      rd(ADR_STATUS, r); chk("ovf_status", r, 32'hE | PAR_FLAG);
      wr(ADR_STATUS, 32'h0);
      rd(ADR_STATUS, r); chk("ovf_cleared", r, 32'h6 | PAR_FLAG);
      n = 0;
      while (!(tx_irq === 1'b1 && sb_q.size() == 0) && n < 2500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", {31'b0, n < 2500}, 32'h1);
      chk("nine_frames", frames - fb, 9);

      // push in the cycle the FSM pops from a full FIFO
      for (int i = 0; i < 9; i++) begin
         b = 8'h30 + 8'(i);
         sb_q.push_back(b);
         bus.MemWrite  = 1'b1;
         bus.Adr       = ADR_TXDATA;
         bus.WriteData = {24'h0, b};
         @(negedge clk);
      end
      bus.MemWrite = 1'b0;
      rd(ADR_STATUS, r); chk("refill_full", r, 32'h6 | PAR_FLAG);
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         rd(ADR_STATUS, r);
         if (!r[ST_BUSY]) found = 1'b1;
         else @(negedge clk);
      end
      chk("pop_cycle_found", {31'b0, found}, 32'h1);
      chk("pop_cycle_status", r, 32'h2 | PAR_FLAG);
      sb_q.push_back(8'h3F);
      wr(ADR_TXDATA, 32'h3F);
      rd(ADR_STATUS, r); chk("push_on_pop", r, 32'h6 | PAR_FLAG);

      // reset during data bit 3 of byte 0x31 (bit3 = 0)
      repeat (72) @(negedge clk);
      chk("in_bit3", {31'b0, tx}, 32'h0);
      reset = 1'b1;
      rst_epoch++;
      @(negedge clk);
      chk("rst_mid_tx", {31'b0, tx}, 32'h1);
      rd(ADR_STATUS, r); chk("rst_mid_status", r, ST_IDLE_VAL);
      rd(ADR_CYCLES, r); chk("rst_mid_cycles", r, 32'h0);
      reset = 1'b0;
      sb_q.delete();
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (tx !== 1'b1) n++;
         @(negedge clk);
      end
      chk("rst_mid_line_idle", n, 0);
      rd(ADR_STATUS, r); chk("rst_mid_discarded", r, ST_IDLE_VAL);
      chk("rst_mid_irq", {31'b0, tx_irq}, 32'h1);

      repeat (200) @(negedge clk);
      chk("end_sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
